// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file for the pipelined CPU core.
//   - 2 combinational read ports: Rs and Rt.
//   - 2 write ports: port 0 is the WB stage, port 1 is the long-latency unit.
//     If both ports write the same register, port 1 wins.
//   - Optional write->read bypass (BYPASS).
//   - One busy bit per register, used by decode to detect hazards and stall.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   we0/waddr0/wdata0        write port 0 (WB stage)
//   we1/waddr1/wdata1        write port 1 (long-latency unit)
//   raddr0/rdata0            read port 0 (Rs)
//   raddr1/rdata1            read port 1 (Rt)
//   issue_we/issue_addr      destination register of a newly issued instruction
//   busy0/busy1              the register on raddr0/raddr1 has a pending producer
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy0,
    output logic              busy1
);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [NREGS-1:0]  busy_r;

    // Qualified write enables. Writes to register 0 (when ZERO_REG is set)
    // and to unimplemented addresses are dropped here. These same enables
    // drive both the storage update and the bypass path.
    logic wv0_s;
    logic wv1_s;
    logic iv_s;

    // The address selects an implemented register.
    function automatic logic implemented(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NREGS));
    endfunction

    // The address selects a register that can hold data and can go busy.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return implemented(a) && !(ZERO_REG && (a == '0));
    endfunction

    // Read mux for one port.
    // An address that reads as zero has priority over any bypass.
    // Within the bypass, port 1 has priority over port 0.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = '0;
        if (!writable(ra)) begin
            v = '0;
        end else if (BYPASS && wv1_s && (waddr1 == ra)) begin
            v = wdata1;
        end else if (BYPASS && wv0_s && (waddr0 == ra)) begin
            v = wdata0;
        end else begin
            // Loop select, so that the index never runs past NREGS.
            for (int i = 0; i < NREGS; i++) begin
                if (ra == ADDR_W'(i)) begin
                    v = regs_r[i];
                end else begin
                    v = v;
                end
            end
        end
        return v;
    endfunction

    // Busy flag for one read port.
    // A pending producer is hidden when its result is being forwarded this cycle.
    function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (ra == ADDR_W'(i)) begin
                b = busy_r[i];
            end else begin
                b = b;
            end
        end
        if (BYPASS && ((wv1_s && (waddr1 == ra)) || (wv0_s && (waddr0 == ra)))) begin
            b = 1'b0;
        end else begin
            b = b;
        end
        return b;
    endfunction

    // Qualify the write and issue enables against the address map.
    always_comb begin
        wv0_s = we0 && writable(waddr0);
        wv1_s = we1 && writable(waddr1);
        iv_s  = issue_we && writable(issue_addr);
    end

    // Register storage. Port 1 overrides port 0 on an address collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                regs_r[i] <= '0;
            end else if (wv1_s && (waddr1 == ADDR_W'(i))) begin
                regs_r[i] <= wdata1;
            end else if (wv0_s && (waddr0 == ADDR_W'(i))) begin
                regs_r[i] <= wdata0;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Scoreboard. A new issue beats a completing write to the same register,
    // because the issued instruction is the younger producer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                busy_r[i] <= 1'b0;
            end else if (iv_s && (issue_addr == ADDR_W'(i))) begin
                busy_r[i] <= 1'b1;
            end else if ((wv1_s && (waddr1 == ADDR_W'(i))) ||
                         (wv0_s && (waddr0 == ADDR_W'(i)))) begin
                busy_r[i] <= 1'b0;
            end else begin
                busy_r[i] <= busy_r[i];
            end
        end
    end

    // Read data and busy outputs. All of them are forced to zero while reset is high.
    always_comb begin
        if (reset) begin
            rdata0 = '0;
            rdata1 = '0;
            busy0  = 1'b0;
            busy1  = 1'b0;
        end else begin
            rdata0 = read_port(raddr0);
            rdata1 = read_port(raddr1);
            busy0  = writable(raddr0) && busy_port(raddr0);
            busy1  = writable(raddr1) && busy_port(raddr1);
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed test of regfile_mp. All three instances receive the same stimulus:
//     dut_a  : default parameters (BYPASS=1, NREGS=32)
//     dut_nb : BYPASS=0
//     dut_s  : NREGS=16
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [4:0]  raddr0;
    logic [4:0]  raddr1;
    logic        issue_we;
    logic [4:0]  issue_addr;

    logic [31:0] a_rdata0,  a_rdata1,  nb_rdata0, nb_rdata1, s_rdata0, s_rdata1;
    logic        a_busy0,   a_busy1,   nb_busy0,  nb_busy1,  s_busy0,  s_busy1;

    int n_pass;
    int n_total;

    regfile_mp dut_a (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(a_rdata0), .rdata1(a_rdata1),
        .issue_we(issue_we), .issue_addr(issue_addr),
        .busy0(a_busy0), .busy1(a_busy1)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(nb_rdata0), .rdata1(nb_rdata1),
        .issue_we(issue_we), .issue_addr(issue_addr),
        .busy0(nb_busy0), .busy1(nb_busy1)
    );

    regfile_mp #(.NREGS(16)) dut_s (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr0(raddr0), .raddr1(raddr1),
        .rdata0(s_rdata0), .rdata1(s_rdata1),
        .issue_we(issue_we), .issue_addr(issue_addr),
        .busy0(s_busy0), .busy1(s_busy1)
    );

    // Free-running clock with a 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for a rising edge, then moves 1 ns past it before the bench drives inputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clears all write and issue strobes
    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        issue_we = 1'b0;
    endtask

    // Directed stimulus and checks
    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        we0 = 1'b0; waddr0 = 5'd0; wdata0 = 32'h0;
        we1 = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
        raddr0 = 5'd0; raddr1 = 5'd0;
        issue_we = 1'b0; issue_addr = 5'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset: preload r8 and mark it busy, then reset for one cycle
        we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h1234abcd;
        tick();
        idle();
        issue_we = 1'b1; issue_addr = 5'd8;
        tick();
        idle();
        raddr0 = 5'd8;
        #1;
        check("preload_r8", a_rdata0, 32'h1234abcd);
        check("preload_busy", {31'd0, a_busy0}, 32'd1);
        reset = 1'b1;
        #1;
        check("in_reset_rdata", a_rdata0, 32'h0);
        check("in_reset_busy", {31'd0, a_busy0}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_rdata", a_rdata0, 32'h0);
        check("post_reset_busy", {31'd0, a_busy0}, 32'd0);

        // Write/bypass: same-cycle forward, or the old value when there is no bypass
        we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h1234abcd; raddr0 = 5'd8;
        #1;
        check("bypass_same_cycle", a_rdata0, 32'h1234abcd);
        check("nobypass_old", nb_rdata0, 32'h0);
        tick();
        idle();
        #1;
        check("nobypass_after_edge", nb_rdata0, 32'h1234abcd);

        // Collision: both ports write r5, and port 1 wins
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h5555FFFF;
        raddr1 = 5'd5;
        #1;
        check("collision_bypass", a_rdata1, 32'h5555FFFF);
        tick();
        idle();
        #1;
        check("collision_stored", a_rdata1, 32'h5555FFFF);
        check("collision_stored_nb", nb_rdata1, 32'h5555FFFF);

        // Zero register: the write and the issue to r0 are dropped
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        issue_we = 1'b1; issue_addr = 5'd0; raddr0 = 5'd0;
        #1;
        check("zero_bypass", a_rdata0, 32'h0);
        tick();
        idle();
        #1;
        check("zero_read", a_rdata0, 32'h0);
        check("zero_busy", {31'd0, a_busy0}, 32'd0);

        // Scoreboard: issue r9, then a write and a re-issue of r9 in the same cycle, then a plain write
        issue_we = 1'b1; issue_addr = 5'd9; raddr1 = 5'd9;
        tick();
        idle();
        #1;
        check("sb_issue", {31'd0, a_busy1}, 32'd1);
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h00000099;
        issue_we = 1'b1; issue_addr = 5'd9;
        #1;
        check("sb_fwd_mask", {31'd0, a_busy1}, 32'd0);
        check("sb_nb_nomask", {31'd0, nb_busy1}, 32'd1);
        tick();
        idle();
        #1;
        check("sb_set_wins", {31'd0, a_busy1}, 32'd1);
        check("sb_data", a_rdata1, 32'h00000099);
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h00000042;
        tick();
        idle();
        #1;
        check("sb_clear", {31'd0, a_busy1}, 32'd0);
        check("sb_clear_nb", {31'd0, nb_busy1}, 32'd0);
        check("sb_new_data", a_rdata1, 32'h00000042);

        // Unimplemented address: r20 does not exist when NREGS=16
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h00000044;
        tick();
        idle();
        we0 = 1'b1; waddr0 = 5'd20; wdata0 = 32'h00000077;
        issue_we = 1'b1; issue_addr = 5'd20;
        raddr0 = 5'd20; raddr1 = 5'd4;
        #1;
        check("unimpl_bypass", s_rdata0, 32'h0);
        tick();
        idle();
        #1;
        check("unimpl_read", s_rdata0, 32'h0);
        check("unimpl_busy", {31'd0, s_busy0}, 32'd0);
        check("unimpl_r4_intact", s_rdata1, 32'h00000044);
        check("full_r20_written", a_rdata0, 32'h00000077);
        check("full_r20_busy", {31'd0, a_busy0}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
